// File: rtl/eth_evt_sync_pkg.sv
// rtl/eth_evt_sync_pkg.sv - shared encodings and helpers for the event synchroniser
package eth_evt_sync_pkg;

   localparam logic [1:0] EDGE_RISE = 2'd0;
   localparam logic [1:0] EDGE_FALL = 2'd1;
   localparam logic [1:0] EDGE_BOTH = 2'd2;
   localparam logic [1:0] EDGE_OFF  = 2'd3;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/eth_evt_sync_ch.sv
// rtl/eth_evt_sync_ch.sv - one channel: sync chain, edge decode, pending flag and event counter
module eth_evt_sync_ch
   import eth_evt_sync_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             async_in,
   input  logic [1:0]       edge_sel,
   input  logic             warm_done,
   input  logic             ack,
   input  logic             cnt_clr,
   output logic             level_out,
   output logic             event_pulse,
   output logic             pend,
   output logic             ovf,
   output logic [CNT_W-1:0] cnt
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise;
   logic                   fall;
   logic                   hit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      end
   end

   assign level_out = sync_q[SYNC_STAGES-1];

   always_comb begin
      rise = level_out & ~prev_q;
      fall = ~level_out & prev_q;
      hit  = 1'b0;
      case (edge_sel)
         EDGE_RISE: hit = rise;
         EDGE_FALL: hit = fall;
         EDGE_BOTH: hit = rise | fall;
         default:   hit = 1'b0;
      endcase
   end

   // prev tracks level_out even during warm-up so the first enabled cycle sees no stale edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q      <= 1'b0;
         event_pulse <= 1'b0;
      end else begin
         prev_q      <= level_out;
         event_pulse <= hit & warm_done;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend <= 1'b0;
      end else if (event_pulse) begin
         pend <= 1'b1;
      end else if (ack) begin
         pend <= 1'b0;
      end
   end

   // A clear that coincides with an event keeps that event: the count restarts at one
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (cnt_clr) begin
         cnt <= event_pulse ? CNT_W'(1) : '0;
         ovf <= 1'b0;
      end else if (event_pulse) begin
         if (cnt == {CNT_W{1'b1}}) begin
            ovf <= 1'b1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/eth_evt_sync.sv
// rtl/eth_evt_sync.sv - multi-channel event synchroniser with counters and interrupt aggregation
module eth_evt_sync
   import eth_evt_sync_pkg::*;
#(
   parameter  int NUM_CH      = 4,
   parameter  int SYNC_STAGES = 2,
   parameter  int CNT_W       = 8,
   localparam int SEL_W       = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_CH-1:0]   async_in,
   input  logic [2*NUM_CH-1:0] edge_sel,
   input  logic [NUM_CH-1:0]   irq_mask,
   input  logic [NUM_CH-1:0]   ack,
   input  logic [SEL_W-1:0]    cnt_sel,
   input  logic                cnt_clr,
   output logic [NUM_CH-1:0]   level_out,
   output logic [NUM_CH-1:0]   event_pulse,
   output logic [NUM_CH-1:0]   pend,
   output logic [NUM_CH-1:0]   ovf,
   output logic [CNT_W-1:0]    cnt_data,
   output logic                irq
);

   localparam int WARM_MAX = SYNC_STAGES + 1;
   localparam int WARM_W   = clog2(SYNC_STAGES + 2);

   logic [WARM_W-1:0] warm_cnt;
   logic              warm_done;
   logic [NUM_CH-1:0] clr_vec;
   logic [CNT_W-1:0]  cnt_arr [NUM_CH];

   // Edges are ignored until the chains have flushed whatever was present at reset
   assign warm_done = (warm_cnt == WARM_W'(WARM_MAX));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         warm_cnt <= '0;
      end else if (!warm_done) begin
         warm_cnt <= warm_cnt + WARM_W'(1);
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign clr_vec[g] = cnt_clr && (cnt_sel == SEL_W'(g));

      eth_evt_sync_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_W       (CNT_W)
      ) u_ch (
         .clk         (clk),
         .reset_n     (reset_n),
         .async_in    (async_in[g]),
         .edge_sel    (edge_sel[2*g +: 2]),
         .warm_done   (warm_done),
         .ack         (ack[g]),
         .cnt_clr     (clr_vec[g]),
         .level_out   (level_out[g]),
         .event_pulse (event_pulse[g]),
         .pend        (pend[g]),
         .ovf         (ovf[g]),
         .cnt         (cnt_arr[g])
      );
   end

   // Out-of-range selects match no channel and read back zero
   always_comb begin
      cnt_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cnt_sel == SEL_W'(i)) begin
            cnt_data = cnt_arr[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq <= 1'b0;
      end else begin
         irq <= |(pend & irq_mask);
      end
   end

endmodule

// File: tb/tb_eth_evt_sync.sv
// tb/tb_eth_evt_sync.sv - directed self-checking bench for eth_evt_sync
module tb_eth_evt_sync;

   logic       clk;
   logic       reset_n;
   logic [3:0] async_in;
   logic [7:0] edge_sel;
   logic [3:0] irq_mask;
   logic [3:0] ack;
   logic [1:0] cnt_sel;
   logic       cnt_clr;
   logic [3:0] level_out;
   logic [3:0] event_pulse;
   logic [3:0] pend;
   logic [3:0] ovf;
   logic [7:0] cnt_data;
   logic       irq;

   int checks;
   int errors;

   eth_evt_sync #(
      .NUM_CH      (4),
      .SYNC_STAGES (2),
      .CNT_W       (8)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .async_in    (async_in),
      .edge_sel    (edge_sel),
      .irq_mask    (irq_mask),
      .ack         (ack),
      .cnt_sel     (cnt_sel),
      .cnt_clr     (cnt_clr),
      .level_out   (level_out),
      .event_pulse (event_pulse),
      .pend        (pend),
      .ovf         (ovf),
      .cnt_data    (cnt_data),
      .irq         (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      logic [3:0] seen;
      async_in = 4'b0001;
      tick(2);
      checks++;
      if (level_out !== 4'b0000) begin errors++; $display("FAIL rst_level: got %b expected %b", level_out, 4'b0000); end
      checks++;
      if (event_pulse !== 4'b0000) begin errors++; $display("FAIL rst_event: got %b expected %b", event_pulse, 4'b0000); end
      checks++;
      if (cnt_data !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected %0d", cnt_data, 0); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected %b", irq, 1'b0); end
      reset_n = 1'b1;
      seen = 4'b0000;
      tick(1);
      seen |= event_pulse;
      checks++;
      if (level_out[0] !== 1'b0) begin errors++; $display("FAIL warm_level_early: got %b expected %b", level_out[0], 1'b0); end
      tick(1);
      seen |= event_pulse;
      checks++;
      if (level_out[0] !== 1'b1) begin errors++; $display("FAIL warm_level: got %b expected %b", level_out[0], 1'b1); end
      repeat (8) begin
         tick(1);
         seen |= event_pulse;
      end
      checks++;
      if (seen !== 4'b0000) begin errors++; $display("FAIL warm_no_event: got %b expected %b", seen, 4'b0000); end
      checks++;
      if (cnt_data !== 8'd0) begin errors++; $display("FAIL warm_cnt0: got %0d expected %0d", cnt_data, 0); end
      checks++;
      if (pend !== 4'b0000) begin errors++; $display("FAIL warm_pend: got %b expected %b", pend, 4'b0000); end
      async_in = 4'b0000;
      tick(4);
   endtask

   task automatic test_rise_ch1;
      irq_mask = 4'b0010;
      for (int p = 0; p < 3; p++) begin
         async_in[1] = 1'b1;
         tick(2);
         checks++;
         if (event_pulse[1] !== 1'b0) begin errors++; $display("FAIL rise_early p%0d: got %b expected %b", p, event_pulse[1], 1'b0); end
         tick(1);
         async_in[1] = 1'b0;
         checks++;
         if (event_pulse[1] !== 1'b1) begin errors++; $display("FAIL rise_pulse p%0d: got %b expected %b", p, event_pulse[1], 1'b1); end
         tick(1);
         checks++;
         if (event_pulse[1] !== 1'b0) begin errors++; $display("FAIL rise_width p%0d: got %b expected %b", p, event_pulse[1], 1'b0); end
         if (p == 0) begin
            checks++;
            if (pend[1] !== 1'b1) begin errors++; $display("FAIL rise_pend: got %b expected %b", pend[1], 1'b1); end
            checks++;
            if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq_lag: got %b expected %b", irq, 1'b0); end
            tick(1);
            checks++;
            if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq: got %b expected %b", irq, 1'b1); end
         end else begin
            tick(1);
         end
         tick(3);
      end
      cnt_sel = 2'd1;
      #1;
      checks++;
      if (cnt_data !== 8'd3) begin errors++; $display("FAIL rise_count: got %0d expected %0d", cnt_data, 3); end
      checks++;
      if (pend[1] !== 1'b1) begin errors++; $display("FAIL rise_pend_hold: got %b expected %b", pend[1], 1'b1); end
      ack = 4'b0010;
      tick(1);
      ack = 4'b0000;
      tick(2);
   endtask

   task automatic test_both_ch2;
      int n;
      edge_sel[5:4] = 2'd2;
      n = 0;
      for (int i = 0; i < 14; i++) begin
         if (i == 0) async_in[2] = 1'b1;
         if (i == 5) async_in[2] = 1'b0;
         tick(1);
         n += int'(event_pulse[2]);
      end
      cnt_sel = 2'd2;
      #1;
      checks++;
      if (n !== 2) begin errors++; $display("FAIL both_events: got %0d expected %0d", n, 2); end
      checks++;
      if (cnt_data !== 8'd2) begin errors++; $display("FAIL both_count: got %0d expected %0d", cnt_data, 2); end
      edge_sel[5:4] = 2'd3;
      n = 0;
      for (int i = 0; i < 14; i++) begin
         if (i == 0) async_in[2] = 1'b1;
         if (i == 5) async_in[2] = 1'b0;
         tick(1);
         n += int'(event_pulse[2]);
      end
      checks++;
      if (n !== 0) begin errors++; $display("FAIL off_events: got %0d expected %0d", n, 0); end
      checks++;
      if (cnt_data !== 8'd2) begin errors++; $display("FAIL off_count: got %0d expected %0d", cnt_data, 2); end
   endtask

   task automatic test_saturate_ch0;
      edge_sel[1:0] = 2'd2;
      cnt_sel = 2'd0;
      for (int i = 0; i < 255; i++) begin
         async_in[0] = ~async_in[0];
         tick(2);
      end
      tick(4);
      checks++;
      if (cnt_data !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected %0d", cnt_data, 255); end
      checks++;
      if (ovf[0] !== 1'b0) begin errors++; $display("FAIL sat_no_ovf: got %b expected %b", ovf[0], 1'b0); end
      async_in[0] = ~async_in[0];
      tick(5);
      checks++;
      if (cnt_data !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected %0d", cnt_data, 255); end
      checks++;
      if (ovf[0] !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b expected %b", ovf[0], 1'b1); end
      async_in[0] = ~async_in[0];
      tick(3);
      checks++;
      if (event_pulse[0] !== 1'b1) begin errors++; $display("FAIL clr_event: got %b expected %b", event_pulse[0], 1'b1); end
      cnt_clr = 1'b1;
      tick(1);
      cnt_clr = 1'b0;
      checks++;
      if (cnt_data !== 8'd1) begin errors++; $display("FAIL clr_coincide: got %0d expected %0d", cnt_data, 1); end
      checks++;
      if (ovf[0] !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b expected %b", ovf[0], 1'b0); end
      cnt_clr = 1'b1;
      tick(1);
      cnt_clr = 1'b0;
      checks++;
      if (cnt_data !== 8'd0) begin errors++; $display("FAIL clr_plain: got %0d expected %0d", cnt_data, 0); end
      cnt_sel = 2'd1;
      #1;
      checks++;
      if (cnt_data !== 8'd3) begin errors++; $display("FAIL clr_other_ch: got %0d expected %0d", cnt_data, 3); end
      edge_sel[1:0] = 2'd3;
      async_in[0] = 1'b0;
      tick(5);
   endtask

   task automatic test_ack_ch3;
      irq_mask = 4'b1000;
      ack = 4'b1111;
      tick(1);
      ack = 4'b0000;
      tick(2);
      checks++;
      if (pend !== 4'b0000) begin errors++; $display("FAIL ack_all: got %b expected %b", pend, 4'b0000); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL ack_irq_idle: got %b expected %b", irq, 1'b0); end
      async_in[3] = 1'b1;
      tick(3);
      checks++;
      if (event_pulse[3] !== 1'b1) begin errors++; $display("FAIL ack_event: got %b expected %b", event_pulse[3], 1'b1); end
      ack = 4'b1000;
      tick(1);
      ack = 4'b0000;
      checks++;
      if (pend[3] !== 1'b1) begin errors++; $display("FAIL ack_set_wins: got %b expected %b", pend[3], 1'b1); end
      ack = 4'b1000;
      tick(1);
      ack = 4'b0000;
      checks++;
      if (pend[3] !== 1'b0) begin errors++; $display("FAIL ack_clear: got %b expected %b", pend[3], 1'b0); end
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL ack_irq_lag: got %b expected %b", irq, 1'b1); end
      tick(1);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL ack_irq_drop: got %b expected %b", irq, 1'b0); end
      async_in[3] = 1'b0;
      tick(4);
   endtask

   task automatic test_reset_mid;
      logic [3:0] seen;
      irq_mask = 4'b0010;
      edge_sel[1:0] = 2'd2;
      async_in[1] = 1'b1;
      tick(5);
      cnt_sel = 2'd1;
      #1;
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq_before: got %b expected %b", irq, 1'b1); end
      checks++;
      if (cnt_data !== 8'd4) begin errors++; $display("FAIL mid_cnt_before: got %0d expected %0d", cnt_data, 4); end
      async_in[0] = 1'b1;
      tick(1);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (level_out !== 4'b0000) begin errors++; $display("FAIL mid_level: got %b expected %b", level_out, 4'b0000); end
      checks++;
      if (pend !== 4'b0000) begin errors++; $display("FAIL mid_pend: got %b expected %b", pend, 4'b0000); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b expected %b", irq, 1'b0); end
      checks++;
      if (cnt_data !== 8'd0) begin errors++; $display("FAIL mid_cnt: got %0d expected %0d", cnt_data, 0); end
      checks++;
      if (event_pulse !== 4'b0000 || ovf !== 4'b0000) begin errors++; $display("FAIL mid_evt_ovf: got %b/%b expected %b/%b", event_pulse, ovf, 4'b0000, 4'b0000); end
      tick(2);
      reset_n = 1'b1;
      seen = 4'b0000;
      tick(2);
      seen |= event_pulse;
      checks++;
      if (level_out !== 4'b0011) begin errors++; $display("FAIL mid_relevel: got %b expected %b", level_out, 4'b0011); end
      repeat (6) begin
         tick(1);
         seen |= event_pulse;
      end
      checks++;
      if (seen !== 4'b0000) begin errors++; $display("FAIL mid_warm: got %b expected %b", seen, 4'b0000); end
      checks++;
      if (cnt_data !== 8'd0) begin errors++; $display("FAIL mid_cnt_after: got %0d expected %0d", cnt_data, 0); end
      async_in[0] = 1'b0;
      tick(3);
      checks++;
      if (event_pulse[0] !== 1'b1) begin errors++; $display("FAIL mid_resume: got %b expected %b", event_pulse[0], 1'b1); end
      tick(4);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset_n  = 1'b0;
      async_in = 4'b0000;
      edge_sel = 8'h00;
      irq_mask = 4'b0000;
      ack      = 4'b0000;
      cnt_sel  = 2'd0;
      cnt_clr  = 1'b0;
      test_reset();
      test_rise_ch1();
      test_both_ch2();
      test_saturate_ch0();
      test_ack_ch3();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/eth_evt_sync.md
Name: eth_evt_sync

Overview:
- Multi-channel event synchroniser for the eth_ocm MAC. Brings NUM_CH asynchronous status lines (PHY link/interrupt, foreign-domain done strobes) into the single clk domain.
- Per channel: programmable edge detection, a sticky pending flag with acknowledge, and a saturating event counter.
- Successor to the single-bit two-clock pulse synchroniser: generalised in channel count, sync depth and edge mode, and adds counting and interrupt aggregation.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- SYNC_STAGES, 2, flip-flops in each synchroniser chain (>=2).
- CNT_W, 8, width of each per-channel event counter.

Ports:
- clk  input  1  sole clock.
- reset_n  input  1  asynchronous active-low reset.
- async_in  input  NUM_CH  asynchronous event/level inputs, one bit per channel.
- edge_sel  input  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 0 rising, 1 falling, 2 both, 3 disabled.
- irq_mask  input  NUM_CH  1 = channel contributes to irq.
- ack  input  NUM_CH  one-cycle pulse, clears the pending flag.
- cnt_sel  input  max(1,$clog2(NUM_CH))  counter read/clear channel select.
- cnt_clr  input  1  one-cycle pulse, clears the counter and ovf of channel cnt_sel.
- level_out  output  NUM_CH  synchronised level (last chain stage).
- event_pulse  output  NUM_CH  one-cycle registered pulse per detected edge.
- pend  output  NUM_CH  sticky pending flags.
- ovf  output  NUM_CH  sticky counter-saturation flags.
- cnt_data  output  CNT_W  counter value of channel cnt_sel (combinational mux of registers).
- irq  output  1  registered OR of (pend & irq_mask).

Behaviour:
- Reset (reset_n low, async assert): all sync stages, the prev-level register, event_pulse, pend, ovf, counters and irq are 0; level_out = 0; cnt_data = 0. Deassertion must be externally synchronised to clk.
- Warm-up: a counter of width >= $clog2(SYNC_STAGES+2) suppresses edge detection for SYNC_STAGES+1 cycles after reset release. An input already high at reset therefore produces no event. level_out is valid throughout.
- Latency: input change sampled at edge 0 -> level_out changes after edge SYNC_STAGES-1 -> event_pulse high for exactly the cycle after edge SYNC_STAGES. irq follows pend by one cycle.
- Edge detect: prev <= level_out every cycle.
  - rise = level_out & ~prev; fall = ~level_out & prev.
  - Mode 2 fires on either edge; mode 3 never fires.
  - edge_sel is sampled each cycle; a change affects only edges detected from the next cycle on.
- Minimum guaranteed input pulse width: 1 clk period plus setup/hold. Narrower pulses may be lost (no async capture latch).
- pend[i]: set on event_pulse[i]. Cleared by ack[i]. If set and ack coincide, set wins and pend stays 1. ack on an idle channel has no effect.
- Counter[i]: +1 per event.
  - At all-ones it holds and ovf[i] is set on the next event.
  - cnt_clr targeting i: counter <= 0, ovf <= 0. If an event coincides with the clear, counter <= 1 and ovf <= 0.
  - cnt_sel >= NUM_CH: cnt_data = 0 and cnt_clr is ignored.
- Channels are fully independent; simultaneous events on all channels are each recorded.
- Reset mid-operation clears everything and restarts warm-up; partially synchronised values are discarded.

Decomposition:
- Package eth_evt_sync_pkg holds the edge_sel encodings (EDGE_RISE=2'd0, EDGE_FALL=2'd1, EDGE_BOTH=2'd2, EDGE_OFF=2'd3) and a clog2 helper function.
- Sub-module eth_evt_sync_ch, one per channel, generated NUM_CH times. It contains the sync chain, prev register, edge decode, pend, counter and ovf, with warm-up gating as an input.
- The top level holds the warm-up counter, irq register, cnt_sel read mux and cnt_clr decode.

Test Plan:
- Reset with async_in = 4'b0001, release, hold 10 cycles -> event_pulse never asserts, level_out[0] = 1 after SYNC_STAGES cycles, counter0 = 0.
- ch1 mode rising, 3 high pulses each 3 clk wide -> three event_pulse[1] single-cycle pulses, each SYNC_STAGES+1 cycles after the rise; cnt_sel=1 gives cnt_data = 3; pend[1] = 1; with irq_mask[1] = 1, irq = 1 one cycle after pend.
- ch2 mode both, one high pulse of 5 cycles -> two events, counter2 = 2. Switch to mode 3 and pulse again -> counter stays 2.
- CNT_W=8: 256 events on ch0 -> cnt_data = 255, ovf[0] = 1. Then cnt_clr with cnt_sel=0 coincident with an event -> cnt_data = 1, ovf[0] = 0.
- ack[3] in the same cycle as event_pulse[3] -> pend[3] remains 1. A lone ack[3] the next cycle -> pend[3] = 0, irq drops the following cycle.
- Assert reset_n low mid-stream with pending and counted events -> all outputs 0 immediately; after release, warm-up suppresses events for SYNC_STAGES+1 cycles.
